seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Moore serial-pattern detector: the generalised successor of the fixed 1010 overlapping detector. It samples one bit per qualified cycle and compares it against a runtime-loadable pattern of programmable length (1..PAT_W). Overlapping or non-overlapping mode is selectable, and a saturating match counter is provided. It sits between a serial bit source and control/status logic that needs a registered match flag and a match tally.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width (≥1).
- RST_PAT, 8'b0000_1010: pattern value loaded at reset (low RST_LEN bits used).
- RST_LEN, 4: pattern length loaded at reset (1..PAT_W).
- RST_OVERLAP, 1: overlap mode loaded at reset.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  1  serial data bit.
- in_valid  in  1  x is sampled this cycle.
- cfg_load  in  1  latch cfg_* and restart detection.
- cfg_pat  in  PAT_W  pattern; bit cfg_len-1 is the first bit expected.
- cfg_len  in  LEN_W  pattern length, LEN_W = $clog2(PAT_W+1).
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  Moore match flag.
- match_cnt  out  CNT_W  saturating count of matches.
- cnt_sat  out  1  match_cnt at all-ones.

## Operation
- State: hist[PAT_W-1:0] (newest bit in bit 0), fill (0..PAT_W), hit (drives z), latched pat/len/overlap.
- Reset: pat/len/overlap = RST_*; hist = 0, fill = 0, hit = 0, match_cnt = 0; so z = 0 and cnt_sat = 0.
- cfg_load = 1: latch cfg_pat, cfg_len, cfg_overlap; clear hist, fill and hit. match_cnt is untouched. Has priority over in_valid in the same cycle, and that bit is dropped.
- cfg_len = 0 disables matching (z stays 0). cfg_len > PAT_W is clamped to PAT_W.
- in_valid = 1 (no cfg_load):
  - hist_n = {hist[PAT_W-2:0], x}; fill_n = min(fill+1, len).
  - match = (fill_n == len) && (hist_n & mask) == (pat & mask), where mask = low len bits set.
  - hit <= match.
  - On match with overlap = 0: fill <= 0, so the next match needs len fresh bits. With overlap = 1: fill stays at len.
- in_valid = 0: hist, fill and hit hold, so z holds its value.
- Moore: z = hit and depends only on registered state, never on x the same cycle.
- Counter: on match, match_cnt increments, saturating at 2^CNT_W-1. cnt_sat = (match_cnt == all-ones).
  - cnt_clr alone sets 0.
  - cnt_clr with a simultaneous match sets 1.
  - cnt_clr with cfg_load is applied normally.

## Timing
- Latency: the bit completing the pattern is sampled at edge k. z = 1 and match_cnt is updated after edge k. z stays 1 until the next accepted bit or cfg_load.
- Back-to-back overlapping matches give z = 1 on consecutive accepted bits (e.g. pattern 11, stream 111).
- Reset assertion mid-pattern clears immediately and asynchronously. Deassertion is synchronised upstream.
- Throughput: one bit per cycle, with no stall.

## Structure
- Package seq_det_pkg holds:
  - the LEN_W computation function;
  - a len-to-mask function;
  - a typedef for the latched config struct {pat, len, overlap}.
- One sub-module: sat_counter (parameter W; inc, clr, cnt, sat), instantiated for match_cnt.
- The remainder (history, fill, compare, hit) stays in seq_detector_param.

## Test plan
- Reset defaults (1010, len 4, overlap) with stream 1,0,1,0,1,0 -> z = 1 after bits 4 and 6 only; match_cnt = 2.
- cfg_load pat 1010, len 4, overlap 0, same stream -> z = 1 after bit 4 only; match_cnt = 1.
- cfg_load pat 111, len 3, overlap 1; stream 1,1,1,1 with in_valid low for 2 cycles between bits 2 and 3 -> z = 1 after bits 3 and 4; z holds through the idle cycles; match_cnt = 2.
- CNT_W = 2 instance, len 1, pat 1, seven 1s -> match_cnt = 3 and cnt_sat = 1 from the third match onward. cnt_clr together with the next match -> match_cnt = 1.
- Stream 1,0,1, then cfg_load (same config) together with x = 0, in_valid = 1, then 0 -> no match (history cleared, bit dropped), z = 0. Then 1,0,1,0 -> single match.
- rst_n pulsed low while z = 1 and len = 3 is loaded -> z = 0 and match_cnt = 0 immediately; the config reverts to RST_*.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial-pattern detector.
package seq_det_pkg;

  localparam int MAX_PAT_W = 64;
  localparam int CFG_LEN_W = 8;

  typedef struct packed {
    logic [MAX_PAT_W-1:0] pat;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
  } cfg_t;

  function automatic int calc_len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic logic [MAX_PAT_W-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAT_W; i++) m[i] = (i < int'(len));
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment lands on 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q;

  assign sat = &cnt_q;
  assign cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= inc ? W'(1) : '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with runtime-loadable pattern, length and overlap mode.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             PAT_W       = 8,
  parameter int             CNT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PAT   = PAT_W'(8'b0000_1010),
  parameter int             RST_LEN     = 4,
  parameter bit             RST_OVERLAP = 1'b1,
  localparam int            LEN_W       = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam cfg_t RST_CFG = '{
    pat:     MAX_PAT_W'(RST_PAT),
    len:     (RST_LEN > PAT_W) ? CFG_LEN_W'(PAT_W) : CFG_LEN_W'(RST_LEN),
    overlap: RST_OVERLAP
  };

  function automatic logic [CFG_LEN_W-1:0] clamp_len(input int unsigned l);
    return (l > PAT_W) ? CFG_LEN_W'(PAT_W) : CFG_LEN_W'(l);
  endfunction

  cfg_t                 cfg_q, cfg_d;
  logic [PAT_W-1:0]     hist_q, hist_d;
  logic [CFG_LEN_W-1:0] fill_q, fill_d, fill_inc;
  logic                 hit_q;
  logic                 match;

  always_comb begin
    cfg_d    = '{pat: MAX_PAT_W'(cfg_pat), len: clamp_len(cfg_len), overlap: cfg_overlap};
    hist_d   = {hist_q[PAT_W-2:0], x};
    fill_inc = fill_q + CFG_LEN_W'(1);
    fill_d   = (fill_inc > cfg_q.len) ? cfg_q.len : fill_inc;
    // A zero length would trivially match an empty mask, so it is excluded explicitly.
    match    = in_valid && !cfg_load && (cfg_q.len != '0) && (fill_d == cfg_q.len) &&
               (((MAX_PAT_W'(hist_d) ^ cfg_q.pat) & len_mask(cfg_q.len)) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= RST_CFG;
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else if (cfg_load) begin
      cfg_q  <= cfg_d;
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else if (in_valid) begin
      hist_q <= hist_d;
      hit_q  <= match;
      fill_q <= (match && !cfg_q.overlap) ? '0 : fill_d;
    end
  end

  assign z = hit_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (cnt_clr),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default and 2-bit-counter instances.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x, in_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       z, cnt_sat;
  logic [7:0] match_cnt;

  logic       x2, in_valid2, cnt_clr2;
  logic       z2, cnt_sat2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.CNT_W(2), .RST_PAT(8'b0000_0001), .RST_LEN(1), .RST_OVERLAP(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .in_valid(in_valid2), .cfg_load(1'b0),
    .cfg_pat(8'h00), .cfg_len(4'd0), .cfg_overlap(1'b0), .cnt_clr(cnt_clr2),
    .z(z2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic xv, input logic exp_z, input string tag);
    x = xv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(tag, {31'd0, z}, {31'd0, exp_z});
  endtask

  task automatic idle(input int n, input logic exp_z, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, {31'd0, z}, {31'd0, exp_z});
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic clr);
    cfg_pat = p; cfg_len = l; cfg_overlap = ov; cfg_load = 1'b1; cnt_clr = clr;
    @(posedge clk); #1;
    cfg_load = 1'b0; cnt_clr = 1'b0;
    chk("load_z", {31'd0, z}, 32'd0);
  endtask

  task automatic send2(input logic clr, input logic [1:0] exp_cnt, input logic exp_sat, input string tag);
    x2 = 1'b1; in_valid2 = 1'b1; cnt_clr2 = clr;
    @(posedge clk); #1;
    in_valid2 = 1'b0; cnt_clr2 = 1'b0;
    chk({tag, "_cnt"}, {30'd0, match_cnt2}, {30'd0, exp_cnt});
    chk({tag, "_sat"}, {31'd0, cnt_sat2}, {31'd0, exp_sat});
  endtask

  initial begin
    rst_n = 1'b0; x = 0; in_valid = 0; cfg_load = 0; cfg_overlap = 0; cnt_clr = 0;
    cfg_pat = '0; cfg_len = '0; x2 = 0; in_valid2 = 0; cnt_clr2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", {31'd0, z}, 32'd0);
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
    chk("rst_cnt2", {30'd0, match_cnt2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset defaults: 1010, len 4, overlapping.
    send(1, 0, "dflt_b1"); send(0, 0, "dflt_b2"); send(1, 0, "dflt_b3");
    send(0, 1, "dflt_b4"); send(1, 0, "dflt_b5"); send(0, 1, "dflt_b6");
    chk("dflt_cnt", {24'd0, match_cnt}, 32'd2);

    // Non-overlapping, counter cleared alongside the load.
    load(8'b0000_1010, 4'd4, 1'b0, 1'b1);
    chk("novl_clr", {24'd0, match_cnt}, 32'd0);
    send(1, 0, "novl_b1"); send(0, 0, "novl_b2"); send(1, 0, "novl_b3");
    send(0, 1, "novl_b4"); send(1, 0, "novl_b5"); send(0, 0, "novl_b6");
    chk("novl_cnt", {24'd0, match_cnt}, 32'd1);

    // 111 overlapping with idle gaps.
    load(8'b0000_0111, 4'd3, 1'b1, 1'b1);
    send(1, 0, "p111_b1"); send(1, 0, "p111_b2");
    idle(2, 0, "p111_gap");
    send(1, 1, "p111_b3"); send(1, 1, "p111_b4");
    idle(2, 1, "p111_hold");
    chk("p111_cnt", {24'd0, match_cnt}, 32'd2);

    // Zero length disables matching.
    load(8'b0000_1010, 4'd0, 1'b1, 1'b1);
    send(1, 0, "len0_b1"); send(0, 0, "len0_b2"); send(1, 0, "len0_b3"); send(0, 0, "len0_b4");
    chk("len0_cnt", {24'd0, match_cnt}, 32'd0);

    // Over-long length clamps to 8: pattern 10100101.
    load(8'hA5, 4'd15, 1'b1, 1'b0);
    send(1, 0, "clmp_b1"); send(0, 0, "clmp_b2"); send(1, 0, "clmp_b3"); send(0, 0, "clmp_b4");
    send(0, 0, "clmp_b5"); send(1, 0, "clmp_b6"); send(0, 0, "clmp_b7"); send(1, 1, "clmp_b8");
    chk("clmp_cnt", {24'd0, match_cnt}, 32'd1);

    // 2-bit counter saturation and clear-with-match.
    send2(0, 2'd1, 0, "sat_m1"); send2(0, 2'd2, 0, "sat_m2"); send2(0, 2'd3, 1, "sat_m3");
    send2(0, 2'd3, 1, "sat_m4"); send2(0, 2'd3, 1, "sat_m5"); send2(0, 2'd3, 1, "sat_m6");
    send2(0, 2'd3, 1, "sat_m7");
    send2(1, 2'd1, 0, "sat_clrm");
    cnt_clr2 = 1'b1; @(posedge clk); #1; cnt_clr2 = 1'b0;
    chk("sat_clr_only", {30'd0, match_cnt2}, 32'd0);

    // cfg_load with a valid bit drops that bit and clears history.
    load(8'b0000_1010, 4'd4, 1'b1, 1'b1);
    send(1, 0, "drop_b1"); send(0, 0, "drop_b2"); send(1, 0, "drop_b3");
    x = 0; in_valid = 1; cfg_load = 1;
    @(posedge clk); #1;
    in_valid = 0; cfg_load = 0;
    chk("drop_load_z", {31'd0, z}, 32'd0);
    send(0, 0, "drop_b4");
    send(1, 0, "drop_b5"); send(0, 0, "drop_b6"); send(1, 0, "drop_b7"); send(0, 1, "drop_b8");
    chk("drop_cnt", {24'd0, match_cnt}, 32'd1);

    // Asynchronous reset while z is high, then defaults return.
    load(8'b0000_0111, 4'd3, 1'b1, 1'b0);
    send(1, 0, "ar_b1"); send(1, 0, "ar_b2"); send(1, 1, "ar_b3");
    #2 rst_n = 1'b0;
    #1;
    chk("ar_z", {31'd0, z}, 32'd0);
    chk("ar_cnt", {24'd0, match_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(1, 0, "ar_d1"); send(1, 0, "ar_d2"); send(1, 0, "ar_d3");
    send(0, 0, "ar_d4"); send(1, 0, "ar_d5"); send(0, 1, "ar_d6");
    chk("ar_dcnt", {24'd0, match_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
